// File: rtl/dcache_req_queue.sv
// dcache_req_queue
//   Memory-access stage with up to DEPTH outstanding DCache requests.
//   Accepts load/store instructions from the execute side, issues them to the
//   DCache, records in-order data_ok responses and hands completed entries to
//   write-back in program order. A flush kills every resident entry. Killed
//   entries that still wait for data_ok stay resident until the response
//   arrives, so response alignment with the DCache is never lost. Uncached
//   accesses are strongly ordered against every other access.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_*              instruction from execute (valid/ready handshake)
//   flush             pipeline flush, sampled every cycle
//   req_*             DCache request channel (req_addr_ok = accepted)
//   resp_data_ok/     in-order DCache response, one per issued request
//   resp_rdata
//   out_*             completed head entry to write-back (valid/ready)
//   count             number of resident entries
//   proto_err         sticky: data_ok arrived while nothing was awaiting it
module dcache_req_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int INFO_W = 48
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_op,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W/8-1:0]      in_wstrb,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic                     in_uncache,
    input  logic                     in_ex,
    input  logic [INFO_W-1:0]        in_info,
    input  logic                     flush,
    output logic                     req_valid,
    output logic                     req_op,
    output logic [ADDR_W-1:0]        req_addr,
    output logic [DATA_W/8-1:0]      req_wstrb,
    output logic [DATA_W-1:0]        req_wdata,
    output logic                     req_uncache,
    input  logic                     req_addr_ok,
    input  logic                     resp_data_ok,
    input  logic [DATA_W-1:0]        resp_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_rdata,
    output logic                     out_ex,
    output logic [INFO_W-1:0]        out_info,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Per-entry state bits (reset) and payload (not reset).
    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_done;
    logic [DEPTH-1:0]   ent_killed;
    logic [DEPTH-1:0]   ent_op;
    logic [DEPTH-1:0]   ent_ex;
    logic [DEPTH-1:0]   ent_unc;
    logic [INFO_W-1:0]  ent_info  [DEPTH];
    logic [DATA_W-1:0]  ent_rdata [DEPTH];

    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [PTR_W-1:0]   resp_ptr;
    logic [PTR_W-1:0]   scan_idx;
    logic               resp_found;
    logic               unc_pending;
    logic               full;
    logic               order_ok;
    logic               alloc;
    logic               head_done;
    logic               pop;
    logic               resp_fire;

    // The resp pointer is the oldest resident entry that is not yet done.
    // Exception entries are allocated already done, so the scan skips them,
    // and because responses return in order every older non-ex entry is done.
    // NOTE: every variable driven here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        resp_found = 1'b0;
        resp_ptr   = head_ptr;
        scan_idx   = head_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_ptr + PTR_W'(i);
            if (!resp_found && ent_valid[scan_idx] && !ent_done[scan_idx]) begin
                resp_found = 1'b1;
                resp_ptr   = scan_idx;
            end
        end
    end

    // An uncached entry awaiting data_ok blocks every new request.
    assign unc_pending = |(ent_valid & ent_unc & ~ent_done);
    assign full        = (count == CNT_W'(DEPTH));
    assign order_ok    = !(in_uncache && (count != '0)) && !unc_pending;

    assign req_valid   = in_valid && !in_ex && !flush && !full && order_ok;
    assign req_op      = in_op;
    assign req_addr    = in_addr;
    assign req_wstrb   = in_op ? in_wstrb : '0;
    assign req_wdata   = in_wdata;
    assign req_uncache = in_uncache;

    // Exception entries bypass the DCache and need no addr_ok.
    assign in_ready  = !flush && !full && (in_ex || (req_valid && req_addr_ok));
    assign alloc     = in_valid && in_ready;
    assign resp_fire = resp_data_ok && resp_found;

    // A done-and-killed head leaves silently; otherwise it waits for out_ready.
    assign head_done = ent_valid[head_ptr] && ent_done[head_ptr];
    assign out_valid = head_done && !ent_killed[head_ptr];
    assign pop       = head_done && (ent_killed[head_ptr] || out_ready);

    assign out_rdata = out_valid ? ent_rdata[head_ptr] : '0;
    assign out_ex    = out_valid && ent_ex[head_ptr];
    assign out_info  = out_valid ? ent_info[head_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order; later
    // assignments to the same bit intentionally override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            proto_err  <= 1'b0;
            ent_valid  <= '0;
            ent_done   <= '0;
            ent_killed <= '0;
        end else begin
            if (alloc) tail_ptr <= tail_ptr + 1'b1;
            if (pop)   head_ptr <= head_ptr + 1'b1;
            count <= count + CNT_W'(alloc) - CNT_W'(pop);

            if (resp_data_ok && !resp_found) proto_err <= 1'b1;

            if (flush) ent_killed <= ent_killed | ent_valid;
            if (resp_fire) ent_done[resp_ptr] <= 1'b1;
            if (pop) ent_valid[head_ptr] <= 1'b0;
            // Allocation never targets a valid entry (not full), so it cannot
            // collide with the pop, response or flush updates above.
            if (alloc) begin
                ent_valid[tail_ptr]  <= 1'b1;
                ent_done[tail_ptr]   <= in_ex;
                ent_killed[tail_ptr] <= 1'b0;
            end
        end
    end

    // NOTE: payload storage has no reset; it is only observed through entries
    // whose valid/done bits are reset, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_info[tail_ptr]  <= in_info;
            ent_op[tail_ptr]    <= in_op;
            ent_ex[tail_ptr]    <= in_ex;
            ent_unc[tail_ptr]   <= in_uncache;
            ent_rdata[tail_ptr] <= '0;
        end
        if (resp_fire) begin
            ent_rdata[resp_ptr] <= ent_op[resp_ptr] ? '0 : resp_rdata;
        end
    end

endmodule

// File: tb/tb_dcache_req_queue.sv
// tb_dcache_req_queue
//   Randomised bench for dcache_req_queue. A queue-based reference model
//   predicts the handshake outputs each cycle and pushes every expected
//   write-back record into a scoreboard; an independent monitor pops and
//   compares whenever the DUT completes an output handshake.
module tb_dcache_req_queue;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int INFO_W = 48;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_op;
    logic [ADDR_W-1:0]      in_addr;
    logic [DATA_W/8-1:0]    in_wstrb;
    logic [DATA_W-1:0]      in_wdata;
    logic                   in_uncache;
    logic                   in_ex;
    logic [INFO_W-1:0]      in_info;
    logic                   flush;
    logic                   req_valid;
    logic                   req_op;
    logic [ADDR_W-1:0]      req_addr;
    logic [DATA_W/8-1:0]    req_wstrb;
    logic [DATA_W-1:0]      req_wdata;
    logic                   req_uncache;
    logic                   req_addr_ok;
    logic                   resp_data_ok;
    logic [DATA_W-1:0]      resp_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_rdata;
    logic                   out_ex;
    logic [INFO_W-1:0]      out_info;
    logic [$clog2(DEPTH):0] count;
    logic                   proto_err;

    dcache_req_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .INFO_W(INFO_W)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wstrb(in_wstrb), .in_wdata(in_wdata),
        .in_uncache(in_uncache), .in_ex(in_ex), .in_info(in_info),
        .flush(flush),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .req_uncache(req_uncache),
        .req_addr_ok(req_addr_ok),
        .resp_data_ok(resp_data_ok), .resp_rdata(resp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_ex(out_ex), .out_info(out_info),
        .count(count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: one record per resident instruction, oldest first.
    typedef struct {
        logic [INFO_W-1:0] info;
        bit                op;
        bit                ex;
        bit                unc;
        bit                done;
        bit                killed;
        logic [DATA_W-1:0] rdata;
    } ment_t;

    typedef struct {
        logic [INFO_W-1:0] info;
        bit                ex;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    ment_t mq[$];
    exp_t  exp_q[$];
    bit    m_perr;
    bit    exp_alloc;
    bit    force_spur;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs, percentages.
    int p_valid, p_store, p_ex, p_unc, p_flush, p_aok, p_ready, p_resp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic int n_await();
        int n = 0;
        foreach (mq[i]) if (!mq[i].done) n++;
        return n;
    endfunction

    function automatic bit unc_await();
        bit r = 0;
        foreach (mq[i]) if (!mq[i].done && mq[i].unc) r = 1;
        return r;
    endfunction

    // One clock cycle: drive at negedge, predict/compare 1 ns later, then
    // advance the model at the posedge using the values that were driven.
    task automatic do_cycle();
        bit   full, ord_ok, e_req, e_rdy, e_out;
        int   cnt;
        exp_t e;
        @(negedge clk);
        in_valid   = roll(p_valid);
        in_op      = roll(p_store);
        in_addr    = $urandom;
        in_wstrb   = 4'($urandom);
        in_wdata   = $urandom;
        in_uncache = roll(p_unc);
        in_ex      = roll(p_ex);
        in_info    = 48'({$urandom, $urandom});
        flush      = roll(p_flush);
        req_addr_ok = roll(p_aok);
        out_ready  = roll(p_ready);
        resp_rdata = $urandom;
        resp_data_ok = force_spur || (n_await() > 0 && roll(p_resp));
        #1;
        cnt    = mq.size();
        full   = (cnt == DEPTH);
        ord_ok = !(in_uncache && cnt != 0) && !unc_await();
        e_req  = in_valid && !in_ex && !flush && !full && ord_ok;
        e_rdy  = !flush && !full && (in_ex || (e_req && req_addr_ok));
        e_out  = (cnt > 0) && mq[0].done && !mq[0].killed;
        check("count", 64'(count), 64'(cnt));
        check("req_valid", 64'(req_valid), 64'(e_req));
        check("in_ready", 64'(in_ready), 64'(e_rdy));
        check("out_valid", 64'(out_valid), 64'(e_out));
        check("proto_err", 64'(proto_err), 64'(m_perr));
        if (e_req) begin
            check("req_wstrb", 64'(req_wstrb), in_op ? 64'(in_wstrb) : 64'd0);
            check("req_addr", 64'(req_addr), 64'(in_addr));
        end
        if (e_out && out_ready) begin
            e.info  = mq[0].info;
            e.ex    = mq[0].ex;
            e.rdata = mq[0].rdata;
            exp_q.push_back(e);
        end
        exp_alloc = in_valid && e_rdy;
        @(posedge clk);
        model_update();
    endtask

    task automatic model_update();
        int    ri = -1;
        bit    pop_f;
        ment_t t;
        foreach (mq[i]) if (ri < 0 && !mq[i].done) ri = i;
        pop_f = (mq.size() > 0) && mq[0].done && (mq[0].killed || out_ready);
        if (resp_data_ok) begin
            if (ri >= 0) begin
                t = mq[ri];
                t.done  = 1;
                t.rdata = t.op ? '0 : resp_rdata;
                mq[ri]  = t;
            end else begin
                m_perr = 1;
            end
        end
        if (pop_f) t = mq.pop_front();
        if (flush) begin
            foreach (mq[i]) begin
                t = mq[i];
                t.killed = 1;
                mq[i] = t;
            end
        end
        if (exp_alloc) begin
            t.info = in_info; t.op = in_op; t.ex = in_ex; t.unc = in_uncache;
            t.done = in_ex; t.killed = 0; t.rdata = '0;
            mq.push_back(t);
        end
    endtask

    task automatic run(input int n, input int v, input int st, input int ex, input int unc,
                       input int fl, input int aok, input int rdy, input int rsp);
        p_valid = v; p_store = st; p_ex = ex; p_unc = unc;
        p_flush = fl; p_aok = aok; p_ready = rdy; p_resp = rsp;
        repeat (n) do_cycle();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; resp_data_ok = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rdata", 64'(out_rdata), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        mq.delete();
        m_perr = 0;
        reset = 1'b0;
    endtask

    // Monitor: independent of the stimulus process, compares each DUT output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_info", 64'(out_info), 64'(e.info));
                    check("out_ex", 64'(out_ex), 64'(e.ex));
                    check("out_rdata", 64'(out_rdata), 64'(e.rdata));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 0; in_op = 0; in_addr = '0; in_wstrb = '0; in_wdata = '0;
        in_uncache = 0; in_ex = 0; in_info = '0; flush = 0; req_addr_ok = 0;
        resp_data_ok = 0; resp_rdata = '0; out_ready = 0;
        m_perr = 0; force_spur = 0; exp_alloc = 0;
        apply_reset();
        //   n     v   st  ex  unc fl  aok rdy rsp
        run(40,  100,   0,  0,  0,  0, 100, 100, 100); // back-to-back loads
        run(15,  100,   0,  0,  0,  0, 100,   0, 100); // fill to DEPTH, backpressure
        run(40,  100,   0,  0,  0,  0, 100, 100, 100); // release, pointers wrap
        run(80,   70,  50, 30,  0,  0,  80,  80,  60); // exception/store mix
        run(120,  70,  30, 10,  0, 10,  80,  80,  50); // flushes
        run(120,  80,  30,  5, 40,  0,  80,  80,  50); // uncached ordering
        run(2000, 60,  40, 10, 20,  3,  70,  70,  50); // mixed random
        run(60,    0,   0,  0,  0,  0, 100, 100, 100); // drain
        check("drained_count", 64'(count), 64'd0);
        // Spurious response with nothing awaiting: proto_err sets and sticks.
        force_spur = 1;
        do_cycle();
        force_spur = 0;
        run(10,    0,   0,  0,  0,  0, 100, 100, 100);
        check("proto_err_sticky", 64'(proto_err), 64'd1);
        // Reset with entries resident discards them.
        run(20,  100,  30, 20,  0,  0, 100,   0,   0);
        apply_reset();
        run(200,  60,  40, 10, 20,  3,  70,  70,  50);
        run(60,    0,   0,  0,  0,  0, 100, 100, 100);
        @(negedge clk);
        #3;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
